ahb_rr_burst_arb: RTL and testbench



---
 rtl/ahb_rr_burst_arb.sv | 197 +++++++++++++++++++
 tb/tb_ahb_rr_burst_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_burst_arb.sv
// -----------------------------------------------------------------------------
// ahb_rr_burst_arb
//
// Output-stage arbiter for one shared AHB slave port of the L1 bus matrix.
// Four input ports compete for the slave using round-robin. Once a port starts
// a fixed-length burst (or INCR), or issues a locked sequence, it keeps the
// grant until that sequence ends. It drives the same addr_in_port / no_port
// select as the fixed-priority arbiter, so the output mux needs no changes.
//
// Optional build macro: AHB_ARB_QOS_EN
//   When defined, the qos_hi input exists. With qos_hi=1 and a request on
//   port 0, any re-arbitration grants port 0, and rr_ptr is left unchanged.
//   BURST and LOCKED grants are never pre-empted.
//
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   req_port[3:0]  per-port request, bit i = input port i
//   HREADYM        slave-side transfer done; all state advances only when 1
//   HSELM, HTRANSM, HBURSTM, HMASTLOCKM
//                  control signals of the currently granted port
//   qos_hi         (AHB_ARB_QOS_EN only) port 0 high-priority request
//   addr_in_port   granted port index (holds its value while no_port=1)
//   no_port        1 = no port selected
//   arb_hold       1 = grant frozen (burst in progress or locked)
// -----------------------------------------------------------------------------
module ahb_rr_burst_arb #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
`ifdef AHB_ARB_QOS_EN
    input  logic                 qos_hi,
`endif
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 arb_hold
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT  = 2'b01,
        ST_BURST  = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          beat_cnt_q, beat_cnt_d;
    logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]   addr_q, addr_d;
    logic                no_port_q, no_port_d;
    logic                arb_hold_q, arb_hold_d;
    logic                incr_q, incr_d;

    logic                accepted, nonseq_acc, seq_acc;
    logic                end_seen, last_beat, any_req, rearb;
    logic                rr_found, qos_win;
    logic [PORT_W-1:0]   rr_win, winner;

    // Beats remaining after the NONSEQ. SINGLE and INCR both load 0; INCR is
    // tracked separately by incr_q because its length is unbounded.
    function automatic logic [4:0] burst_last(input logic [2:0] hburst);
        case (hburst)
            3'b010, 3'b011: burst_last = 5'd3;
            3'b100, 3'b101: burst_last = 5'd7;
            3'b110, 3'b111: burst_last = 5'd15;
            default:        burst_last = 5'd0;
        endcase
    endfunction

    // A beat only counts when a port actually owns the slave.
    assign accepted   = HSELM & (HTRANSM != TR_IDLE) & ~no_port_q;
    assign nonseq_acc = accepted & (HTRANSM == TR_NONSEQ);
    assign seq_acc    = accepted & (HTRANSM == TR_SEQ);
    // IDLE or a fresh NONSEQ from the owner ends the current burst.
    assign end_seen   = (HTRANSM == TR_IDLE) | (HTRANSM == TR_NONSEQ);
    // Last beat of a fixed burst: this SEQ takes the count down to zero.
    assign last_beat  = seq_acc & (beat_cnt_q <= 5'd1);
    assign any_req    = |req_port;

    // Round-robin search starting just after the last winner.
    always_comb begin
        logic [PORT_W-1:0] cand;
        cand     = '0;
        rr_win   = rr_ptr_q;
        rr_found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = rr_ptr_q + PORT_W'(i);
            if (!rr_found && req_port[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

`ifdef AHB_ARB_QOS_EN
    assign qos_win = qos_hi & req_port[0];
`else
    assign qos_win = 1'b0;
`endif
    assign winner = qos_win ? '0 : rr_win;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            rr_ptr_q   <= PORT_W'(NUM_PORTS - 1);
            addr_q     <= '0;
            no_port_q  <= 1'b1;
            arb_hold_q <= 1'b0;
            incr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            no_port_q  <= no_port_d;
            arb_hold_q <= arb_hold_d;
            incr_q     <= incr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        no_port_d  = no_port_q;
        arb_hold_d = arb_hold_q;
        incr_d     = incr_q;
        rearb      = 1'b0;

        if (HREADYM) begin
            if (nonseq_acc) begin
                beat_cnt_d = burst_last(HBURSTM);
                incr_d     = (HBURSTM == HB_INCR);
            end else if (seq_acc) begin
                beat_cnt_d = (beat_cnt_q == 5'd0) ? 5'd0 : beat_cnt_q - 5'd1;
            end else if (state_q == ST_BURST && HTRANSM == TR_IDLE) begin
                beat_cnt_d = '0;
            end

            // Leaving BURST/LOCKED falls straight into the GRANT rules below,
            // so the grant can move on the same cycle the hold ends.
            case (state_q)
                ST_IDLE, ST_GRANT: rearb = 1'b1;
                ST_BURST:          rearb = incr_q ? end_seen : (last_beat | end_seen);
                ST_LOCKED:         rearb = ~HMASTLOCKM;
                default:           rearb = 1'b1;
            endcase

            if (rearb) begin
                if (HMASTLOCKM && !no_port_q) begin
                    state_d = ST_LOCKED;
                end else if (nonseq_acc && HBURSTM != HB_SINGLE) begin
                    state_d  = ST_BURST;
                    rr_ptr_d = addr_q;
                end else if (any_req) begin
                    state_d   = ST_GRANT;
                    addr_d    = winner;
                    no_port_d = 1'b0;
                    if (!qos_win && (no_port_q || winner != addr_q || nonseq_acc))
                        rr_ptr_d = winner;
                end else if (HSELM && !no_port_q) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d   = ST_IDLE;
                    no_port_d = 1'b1;
                end
            end

            arb_hold_d = (state_d == ST_BURST) || (state_d == ST_LOCKED);
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        addr_in_port = addr_q;
        no_port      = no_port_q;
        arb_hold     = arb_hold_q;
    end

endmodule

// File: tb/tb_ahb_rr_burst_arb.sv
// -----------------------------------------------------------------------------
// tb_ahb_rr_burst_arb
//
// Testbench for ahb_rr_burst_arb. A behavioural model of the arbiter, kept in
// plain integers, predicts the grant, no_port and hold after every clock.
// Directed scenarios come first, followed by a randomized run. Define
// AHB_ARB_QOS_EN to build and exercise the qos_hi port as well.
// -----------------------------------------------------------------------------
module tb_ahb_rr_burst_arb;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic       qos_hi;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic       arb_hold;

    int checks = 0;
    int errors = 0;

    // Model state: owner (-1 = none), last addr shown, last rr winner,
    // mode (0 free, 1 burst, 2 locked), beats still owed (-1 = INCR).
    int m_owner, m_addr, m_last, m_mode, m_left;

    ahb_rr_burst_arb dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
`ifdef AHB_ARB_QOS_EN
        .qos_hi       (qos_hi),
`endif
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .arb_hold     (arb_hold)
    );

    always #5 HCLK = ~HCLK;

    function automatic int beats_after_first(input logic [2:0] b);
        case (b)
            3'd1:       return -1;
            3'd2, 3'd3: return 3;
            3'd4, 3'd5: return 7;
            3'd6, 3'd7: return 15;
            default:    return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1; m_addr = 0; m_last = 3; m_mode = 0; m_left = 0;
    endtask

    task automatic model_step();
        bit granted, acc, free, qw, found;
        int w;
        granted = (m_owner >= 0);
        acc     = granted && HSELM && (HTRANSM != 2'd0);
        free    = (m_mode == 0);
        if (m_mode == 1) begin
            if (acc && HTRANSM == 2'd3 && m_left > 0) begin
                m_left--;
                if (m_left == 0) free = 1;
            end
            if (HTRANSM == 2'd0 || HTRANSM == 2'd2) free = 1;
        end else if (m_mode == 2) begin
            free = !HMASTLOCKM;
        end
        if (free) begin
            m_mode = 0;
            if (HMASTLOCKM && granted) begin
                m_mode = 2;
            end else if (acc && HTRANSM == 2'd2 && HBURSTM != 3'd0) begin
                m_mode = 1;
                m_left = beats_after_first(HBURSTM);
                m_last = m_owner;
            end else if (req_port != 4'd0) begin
                qw = qos_hi && req_port[0];
                w = 0; found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req_port[(m_last + k) % 4]) begin
                        found = 1; w = (m_last + k) % 4;
                    end
                end
                if (qw) w = 0;
                if (!qw && (w != m_owner || (acc && HTRANSM == 2'd2))) m_last = w;
                m_owner = w;
                m_addr  = w;
            end else if (!(HSELM && granted)) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_addr"}, {2'b00, addr_in_port}, 4'(m_addr));
        chk({tag, "_noport"}, {3'b000, no_port}, {3'b000, m_owner < 0});
        chk({tag, "_hold"}, {3'b000, arb_hold}, {3'b000, m_mode != 0});
    endtask

    task automatic tick(input string tag);
        @(posedge HCLK);
        if (HRESETn && HREADYM) model_step();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic [3:0] rq, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lk, input logic rdy);
        req_port = rq; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk; HREADYM = rdy;
    endtask

    // Rotate the grant with SINGLE transfers until port p owns the slave.
    task automatic reach_port(input int p);
        int n;
        n = 0;
        drive(4'b1111, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
        while (addr_in_port != 2'(p) && n < 8) begin
            tick("reach");
            n++;
        end
        chk("reach_port", {2'b00, addr_in_port}, 4'(p));
    endtask

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        qos_hi = 1'b0;
        drive(4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
        HRESETn = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        chk("reset_noport", {3'b000, no_port}, 4'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Round-robin rotation with SINGLE transfers
        drive(4'b1111, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick("rr");
            chk("rr_seq", {2'b00, addr_in_port}, 4'(exp_seq[i]));
        end
        chk("rr_noport", {3'b000, no_port}, 4'd0);

        // INCR8 on port 2
        reach_port(2);
        drive(4'b1111, 1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
        tick("incr8_b1");
        HTRANSM = 2'b11;
        for (int i = 2; i <= 7; i++) begin
            tick("incr8");
            chk("incr8_addr", {2'b00, addr_in_port}, 4'd2);
            chk("incr8_hold", {3'b000, arb_hold}, 4'd1);
        end
        tick("incr8_b8");
        chk("incr8_after", {2'b00, addr_in_port}, 4'd3);

        // WRAP4 on port 1 with a 3-cycle stall
        reach_port(1);
        drive(4'b1111, 1'b1, 2'b10, 3'b010, 1'b0, 1'b1);
        tick("wrap4_b1");
        HTRANSM = 2'b11;
        tick("wrap4_b2");
        HREADYM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("wrap4_stall");
            chk("wrap4_stall_addr", {2'b00, addr_in_port}, 4'd1);
        end
        HREADYM = 1'b1;
        tick("wrap4_b3");
        chk("wrap4_b3_hold", {3'b000, arb_hold}, 4'd1);
        tick("wrap4_b4");
        chk("wrap4_done_addr", {2'b00, addr_in_port}, 4'd2);

        // Locked sequence on port 0
        reach_port(0);
        drive(4'b1111, 1'b1, 2'b10, 3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick("lock");
            chk("lock_addr", {2'b00, addr_in_port}, 4'd0);
        end
        HMASTLOCKM = 1'b0;
        tick("lock_rel");
        chk("lock_rel_addr", {2'b00, addr_in_port}, 4'd1);

        // INCR16 cut short by IDLE, then everything goes quiet
        drive(4'b1111, 1'b1, 2'b10, 3'b111, 1'b0, 1'b1);
        tick("incr16_b1");
        HTRANSM = 2'b11;
        tick("incr16_b2");
        tick("incr16_b3");
        HTRANSM = 2'b00;
        tick("incr16_idle");
        chk("incr16_hold", {3'b000, arb_hold}, 4'd0);
        drive(4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
        tick("quiet");
        chk("quiet_noport", {3'b000, no_port}, 4'd1);

`ifdef AHB_ARB_QOS_EN
        drive(4'b0001, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
        tick("qos_pre");
        qos_hi = 1'b1;
        req_port = 4'b0011;
        tick("qos_win");
        chk("qos_addr", {2'b00, addr_in_port}, 4'd0);
        qos_hi = 1'b0;
        tick("qos_off");
        chk("qos_rr_kept", {2'b00, addr_in_port}, 4'd1);
`endif

        // Asynchronous reset in the middle of a burst
        reach_port(3);
        drive(4'b1111, 1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
        tick("rst_b1");
        HTRANSM = 2'b11;
        tick("rst_b2");
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_model("midrst");
        chk("midrst_hold", {3'b000, arb_hold}, 4'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_port   = 4'($urandom_range(0, 15));
            HSELM      = ($urandom_range(0, 6) != 0);
            HTRANSM    = 2'($urandom_range(0, 3));
            HBURSTM    = 3'($urandom_range(0, 7));
            HMASTLOCKM = ($urandom_range(0, 9) == 0);
            HREADYM    = ($urandom_range(0, 4) != 0);
`ifdef AHB_ARB_QOS_EN
            qos_hi     = ($urandom_range(0, 3) == 0);
`endif
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
